// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
//   Converts the decode-stage hazard flags and the memory busy signals into
//   five-stage pipeline actions: PC / pipeline-register write enables, IF/ID
//   flush and ID/EX bubble insertion. It also sequences the multi-cycle stalls
//   (branch-register dependencies, memory waits and halt drain).
//
//   The optional stall-cycle performance counter is enabled by defining the
//   macro STALL_PERF_CNT_EN. Without it, stall_cycles is tied to zero.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   stall_sig        load-use hazard from decode
//   rs_dep           EX-stage load writes the decode rs
//   br_reg           decode instruction is a branch-register
//   br_ex_dep        EX-stage non-load writes the decode rs
//   flush_req        taken branch resolved in ID
//   imem_stall       instruction memory not ready
//   dmem_stall       data memory not ready (freezes everything)
//   halt_dec         HLT in decode
//   pc_we .. mw_we   write enables (combinational from state and inputs)
//   fd_flush         IF/ID loads a NOP
//   dx_bubble        ID/EX loads a NOP
//   halted           registered, set once the pipeline has drained after HLT
//   stall_cycles     decode-stall cycle count (saturating)
module pipeline_stall_ctrl #(
  parameter int unsigned BR_LD_STALLS  = 2,
  parameter int unsigned BR_ALU_STALLS = 1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_sig,
  input  logic             rs_dep,
  input  logic             br_reg,
  input  logic             br_ex_dep,
  input  logic             flush_req,
  input  logic             imem_stall,
  input  logic             dmem_stall,
  input  logic             halt_dec,
  output logic             pc_we,
  output logic             fd_we,
  output logic             fd_flush,
  output logic             dx_we,
  output logic             dx_bubble,
  output logic             xm_we,
  output logic             mw_we,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned DRAIN_CYCLES = 3;
  localparam logic [1:0]  LD_REM       = 2'(BR_LD_STALLS - 1);
  localparam logic [1:0]  ALU_REM      = 2'(BR_ALU_STALLS - 1);
  localparam logic        LD_MULTI     = (BR_LD_STALLS > 1);
  localparam logic        ALU_MULTI    = (BR_ALU_STALLS > 1);

  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_BR_WAIT    = 2'd1,
    S_HALT_DRAIN = 2'd2,
    S_HALTED     = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] rem_q, rem_d;
  logic [1:0] drain_q, drain_d;
  logic       halted_q;
  logic       dec_stall;
  logic       run_hazard;

  assign run_hazard = stall_sig | (br_reg & rs_dep) | (br_reg & br_ex_dep);

  // State register; dmem_stall freezes all sequencing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RUN;
      rem_q    <= 2'd0;
      drain_q  <= 2'd0;
      halted_q <= 1'b0;
    end else if (!dmem_stall) begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      drain_q  <= drain_d;
      halted_q <= (state_d == S_HALTED);
    end
  end

  // Next state and Mealy pipeline controls, in priority order.
  always_comb begin
    pc_we     = 1'b1;
    fd_we     = 1'b1;
    fd_flush  = 1'b0;
    dx_we     = 1'b1;
    dx_bubble = 1'b0;
    xm_we     = 1'b1;
    mw_we     = 1'b1;
    dec_stall = 1'b0;
    state_d   = state_q;
    rem_d     = rem_q;
    drain_d   = drain_q;

    if (!rst_n || dmem_stall || state_q == S_HALTED) begin
      pc_we = 1'b0;
      fd_we = 1'b0;
      dx_we = 1'b0;
      xm_we = 1'b0;
      mw_we = 1'b0;
    end else if (state_q == S_BR_WAIT || (state_q == S_RUN && run_hazard)) begin
      // Hold PC and IF/ID, push a bubble; flush_req is ignored as the
      // branch has not resolved yet.
      dec_stall = 1'b1;
      pc_we     = 1'b0;
      fd_we     = 1'b0;
      dx_bubble = 1'b1;
      if (state_q == S_BR_WAIT) begin
        rem_d = rem_q - 2'd1;
        if (rem_q <= 2'd1) begin
          state_d = S_RUN;
        end
      end else if (br_reg && rs_dep) begin
        // Load dependency takes precedence when both are flagged.
        if (LD_MULTI) begin
          state_d = S_BR_WAIT;
          rem_d   = LD_REM;
        end
      end else if (br_reg && br_ex_dep) begin
        if (ALU_MULTI) begin
          state_d = S_BR_WAIT;
          rem_d   = ALU_REM;
        end
      end
    end else if (state_q == S_HALT_DRAIN) begin
      pc_we     = 1'b0;
      fd_flush  = 1'b1;
      dx_bubble = 1'b1;
      drain_d   = drain_q - 2'd1;
      if (drain_q <= 2'd1) begin
        state_d = S_HALTED;
      end
    end else if (imem_stall) begin
      pc_we    = 1'b0;
      fd_flush = 1'b1;
    end else if (flush_req) begin
      fd_flush = 1'b1;
    end else if (halt_dec) begin
      pc_we    = 1'b0;
      fd_flush = 1'b1;
      state_d  = S_HALT_DRAIN;
      drain_d  = 2'(DRAIN_CYCLES);
    end
  end

  assign halted = halted_q;

`ifdef STALL_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating count of decode-stall cycles not masked by dmem_stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (dec_stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign stall_cycles = cnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed scenarios followed by
// randomized stimulus against a cycle-level behavioural model.
module tb_pipeline_stall_ctrl;

  localparam int unsigned LD    = 2;
  localparam int unsigned ALU   = 1;
  localparam int unsigned CNT_W = 16;

  localparam logic [7:0] ST = 8'h01;
  localparam logic [7:0] RS = 8'h02;
  localparam logic [7:0] BR = 8'h04;
  localparam logic [7:0] BX = 8'h08;
  localparam logic [7:0] FL = 8'h10;
  localparam logic [7:0] IM = 8'h20;
  localparam logic [7:0] DM = 8'h40;
  localparam logic [7:0] HL = 8'h80;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall_sig = 1'b0, rs_dep = 1'b0, br_reg = 1'b0, br_ex_dep = 1'b0;
  logic flush_req = 1'b0, imem_stall = 1'b0, dmem_stall = 1'b0, halt_dec = 1'b0;
  logic pc_we, fd_we, fd_flush, dx_we, dx_bubble, xm_we, mw_we, halted;
  logic [CNT_W-1:0] stall_cycles;

  pipeline_stall_ctrl #(
    .BR_LD_STALLS (LD),
    .BR_ALU_STALLS(ALU),
    .CNT_W        (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_sig   (stall_sig),
    .rs_dep      (rs_dep),
    .br_reg      (br_reg),
    .br_ex_dep   (br_ex_dep),
    .flush_req   (flush_req),
    .imem_stall  (imem_stall),
    .dmem_stall  (dmem_stall),
    .halt_dec    (halt_dec),
    .pc_we       (pc_we),
    .fd_we       (fd_we),
    .fd_flush    (fd_flush),
    .dx_we       (dx_we),
    .dx_bubble   (dx_bubble),
    .xm_we       (xm_we),
    .mw_we       (mw_we),
    .halted      (halted),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_step = 0;

  // Model: remaining extra branch stalls, remaining drain cycles, halted flag.
  int     m_br_left    = 0;
  int     m_drain_left = 0;
  bit     m_halted     = 1'b0;
  longint m_cnt        = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s step %0d: got %0h want %0h", tag, n_step, obs, exp);
  endtask

  task automatic drive(input logic [7:0] v);
    stall_sig  = v[0];
    rs_dep     = v[1];
    br_reg     = v[2];
    br_ex_dep  = v[3];
    flush_req  = v[4];
    imem_stall = v[5];
    dmem_stall = v[6];
    halt_dec   = v[7];
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef STALL_PERF_CNT_EN
    return 32'(m_cnt);
`else
    return 32'd0;
`endif
  endfunction

  // Assert reset asynchronously mid-cycle; outputs must drop at once.
  task automatic do_reset(input logic [7:0] v);
    @(negedge clk);
    n_step++;
    rst_n = 1'b0;
    drive(v);
    #1;
    check("rst_outs", 32'({pc_we, fd_we, fd_flush, dx_we, dx_bubble, xm_we, mw_we}), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_cnt", 32'(stall_cycles), 32'd0);
    m_br_left    = 0;
    m_drain_left = 0;
    m_halted     = 1'b0;
    m_cnt        = 0;
  endtask

  // One clock of stimulus: drive, compare with model, advance model.
  task automatic step(input logic [7:0] v);
    logic [6:0] e; // {pc, fd, flush, dx, bubble, xm, mw}
    bit stall;
    @(negedge clk);
    n_step++;
    rst_n = 1'b1;
    drive(v);
    #1;
    stall = 1'b0;
    if (m_halted || v[6]) begin
      e = 7'b0000000;
    end else if (m_drain_left > 0) begin
      e = 7'b0111111;
      m_drain_left = m_drain_left - 1;
      if (m_drain_left == 0) m_halted = 1'b1;
    end else if (m_br_left > 0) begin
      e = 7'b0001111;
      stall = 1'b1;
      m_br_left = m_br_left - 1;
    end else if (v[0] || (v[2] && (v[1] || v[3]))) begin
      e = 7'b0001111;
      stall = 1'b1;
      if (v[2] && v[1])      m_br_left = int'(LD) - 1;
      else if (v[2] && v[3]) m_br_left = int'(ALU) - 1;
      else                   m_br_left = 0;
    end else if (v[5]) begin
      e = 7'b0111011;
    end else if (v[4]) begin
      e = 7'b1111011;
    end else if (v[7]) begin
      e = 7'b0111011;
      m_drain_left = 3;
    end else begin
      e = 7'b1101011;
    end
    check("outs", 32'({pc_we, fd_we, fd_flush, dx_we, dx_bubble, xm_we, mw_we}), 32'(e));
    check("halted", 32'(halted), 32'(m_halted_prev(m_halted, stall)));
    check("stall_cycles", 32'(stall_cycles), exp_cnt());
    if (stall && m_cnt < (64'd1 << CNT_W) - 1) m_cnt = m_cnt + 1;
  endtask

  // halted is registered: the sample taken in a cycle reflects the flag before
  // that cycle's update, so recompute it from the pre-update view.
  bit halted_seen = 1'b0;
  function automatic bit m_halted_prev(input bit now, input bit unused_stall);
    bit r;
    r = halted_seen;
    halted_seen = now;
    return r | (unused_stall & 1'b0);
  endfunction

  initial begin
    logic [7:0] v;
    int r;

    // Reset with active hazards must still hold every output low.
    do_reset(ST | BR | RS | FL);
    halted_seen = 1'b0;
    step(8'h00);
    step(8'h00);

    // Load-use: one stall cycle then normal flow.
    step(ST);
    step(8'h00);

    // Branch-register on a load: two stall cycles.
    step(BR | RS);
    step(8'h00);
    step(8'h00);

    // dmem_stall while in BR_WAIT with one stall remaining.
    step(BR | RS);
    step(DM);
    step(DM);
    step(DM);
    step(8'h00);
    step(8'h00);

    // Flush ignored under a stall, honoured alone.
    step(FL | ST);
    step(FL);

    // imem_stall for two cycles.
    step(IM);
    step(IM);

    // ALU dependency, and both dependencies together.
    step(BR | BX);
    step(BR | BX | RS);
    step(8'h00);
    step(8'h00);

    // Halt drain, dmem inside drain, then halted until reset.
    step(HL);
    step(8'h00);
    step(DM);
    step(8'h00);
    step(8'h00);
    step(ST | FL);
    step(8'h00);
    do_reset(8'h00);
    halted_seen = 1'b0;
    step(8'h00);

    // Reset aborts BR_WAIT and HALT_DRAIN.
    step(BR | RS);
    do_reset(BR | RS);
    halted_seen = 1'b0;
    step(8'h00);
    step(HL);
    step(8'h00);
    do_reset(8'h00);
    halted_seen = 1'b0;
    step(8'h00);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 199));
      if ((m_halted && r < 40) || r == 0) begin
        do_reset(8'($urandom));
        halted_seen = 1'b0;
      end else begin
        v = 8'h00;
        v[0] = ($urandom_range(0, 99) < 15);
        v[1] = ($urandom_range(0, 99) < 20);
        v[2] = ($urandom_range(0, 99) < 25);
        v[3] = ($urandom_range(0, 99) < 20);
        v[4] = ($urandom_range(0, 99) < 15);
        v[5] = ($urandom_range(0, 99) < 15);
        v[6] = ($urandom_range(0, 99) < 15);
        v[7] = ($urandom_range(0, 99) < 3);
        step(v);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
